// File: rtl/cordic_scheduler_if.sv
// cordic_scheduler_if: requester-side handshakes and the cordic pipeline bus of the cordic scheduler
interface cordic_scheduler_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ*23-1:0] req_theta;
    logic [N_REQ-1:0] rsp_valid;
    logic [N_REQ-1:0] rsp_ready;
    logic [N_REQ*22-1:0] rsp_result;
    logic [N_REQ-1:0] rsp_err;
    logic cordic_clk_en;
    logic [22:0] cordic_theta;
    logic [21:0] cordic_result;
    modport master(
        output req_valid, req_theta, rsp_ready, cordic_result,
        input req_ready, rsp_valid, rsp_result, rsp_err, cordic_clk_en, cordic_theta
    );
    modport slave(
        input req_valid, req_theta, rsp_ready, cordic_result,
        output req_ready, rsp_valid, rsp_result, rsp_err, cordic_clk_en, cordic_theta
    );
endinterface

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: round-robin sharing of one cordic pipeline; CORDIC_SCHED_RANGE_CHECK_EN flags |theta| > 1.0 as rsp_err
module cordic_scheduler #(
    parameter int N_REQ = 2,
    parameter int LATENCY = 16
) (
    input logic clk,
    input logic reset,
    cordic_scheduler_if.slave bus,
    output logic busy
);
    localparam int IW = $clog2(N_REQ);
    typedef struct packed {
        logic v;
        logic [IW-1:0] id;
        logic err;
    } tagT;
    tagT tags [LATENCY];
    tagT last;
    logic [N_REQ-1:0] outstanding, rspValid, rspErr, eligible;
    logic [N_REQ*22-1:0] rspResult;
    logic [IW-1:0] ptr, winner;
    logic [22:0] selTheta, cordicTheta;
    logic accept, accErr, anyTag, clkEn;
    assign eligible = bus.req_valid & ~outstanding & {N_REQ{reset}};
    assign accept = |eligible;
    // descending scan so the first eligible requester from ptr ends up as winner
    always_comb begin
        winner = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (eligible[(int'(ptr) + k) % N_REQ]) winner = IW'((int'(ptr) + k) % N_REQ);
    end
    assign selTheta = bus.req_theta[int'(winner)*23 +: 23];
`ifdef CORDIC_SCHED_RANGE_CHECK_EN
    assign accErr = $signed(selTheta) > $signed(23'h200000) || $signed(selTheta) < $signed(23'h600000);
`else
    assign accErr = 1'b0;
`endif
    always_comb begin
        anyTag = 1'b0;
        for (int j = 0; j < LATENCY; j++) anyTag = anyTag | tags[j].v;
    end
    assign clkEn = reset && (accept || anyTag);
    assign last = tags[LATENCY-1];
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < LATENCY; j++) tags[j] <= '0;
            ptr <= '0;
            cordicTheta <= '0;
        end else begin
            if (clkEn) begin
                tags[0] <= {accept, winner, accErr & accept};
                for (int j = 1; j < LATENCY; j++) tags[j] <= tags[j-1];
            end
            if (accept) begin
                cordicTheta <= selTheta;
                ptr <= (int'(winner) == N_REQ - 1) ? '0 : IW'(int'(winner) + 1);
            end
        end
    end
    // one outstanding request per requester, so capture and release never hit the same slot together
    always_ff @(posedge clk) begin
        if (!reset) begin
            outstanding <= '0;
            rspValid <= '0;
            rspErr <= '0;
            rspResult <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (rspValid[i] && bus.rsp_ready[i]) begin
                    rspValid[i] <= 1'b0;
                    rspErr[i] <= 1'b0;
                    rspResult[i*22 +: 22] <= '0;
                    outstanding[i] <= 1'b0;
                end
                if (eligible[i] && int'(winner) == i) outstanding[i] <= 1'b1;
                if (last.v && int'(last.id) == i) begin
                    rspValid[i] <= 1'b1;
                    rspErr[i] <= last.err;
                    rspResult[i*22 +: 22] <= last.err ? '0 : bus.cordic_result;
                end
            end
        end
    end
    assign bus.req_ready = accept ? N_REQ'(1) << winner : '0;
    assign bus.rsp_valid = rspValid;
    assign bus.rsp_result = rspResult;
    assign bus.rsp_err = rspErr;
    assign bus.cordic_clk_en = clkEn;
    assign bus.cordic_theta = cordicTheta;
    assign busy = reset && |outstanding;
endmodule
